masked_sram_1w1r: RTL
=====================

// Module: masked_sram_1w1r
// PURPOSE
//  Parametrised 1-write/1-read synchronous RAM with per-lane write mask. Replaces the fixed-size generated array macros.
//  Adds self-clearing init after reset, write-first forwarding on same-address collision, a read-valid strobe, and held read data.
//  Sits under the register-file / cache tag+data arrays of each warp slice. One instance per array.
// PARAMETERS
//  DEPTH    256  number of entries; any value >= 2, need not be a power of two
//  LANE_W   10   bits per mask lane
//  MASK_W   2    number of mask lanes; DATA_W = MASK_W*LANE_W
//  ADDR_W   $clog2(DEPTH)  derived; do not override
// PORTS
//  clock      in   1       single clock for all ports
//  reset      in   1       synchronous, active-high
//  W0_en      in   1       write request
//  W0_addr    in   ADDR_W  write address
//  W0_data    in   DATA_W  write data
//  W0_mask    in   MASK_W  lane g written iff W0_mask[g]
//  R0_en      in   1       read request
//  R0_addr    in   ADDR_W  read address
//  R0_data    out  DATA_W  read data, registered
//  R0_valid   out  1       R0_data updated this cycle from an accepted read
//  init_busy  out  1       clear sweep in progress; all requests ignored
// BEHAVIOUR
//  Reset: R0_data=0, R0_valid=0, init_busy=1, state=INIT, sweep counter=0. Reset asserted mid-sweep or mid-traffic restarts the sweep at entry 0.
//  FSM INIT: each cycle writes all-zero (all lanes) to ram[cnt], cnt++; after writing DEPTH-1 -> READY next cycle. Sweep takes exactly DEPTH cycles after reset deasserts.
//  FSM READY: init_busy=0; stays until reset. No other transitions.
//  In INIT: W0_en and R0_en ignored; no ram update from port W0; R0_valid=0; R0_data holds.
//  Write (READY, W0_en=1): at clock edge, ram[W0_addr] lane g <= W0_data lane g for each set W0_mask[g]; others unchanged. W0_mask=0 is a no-op.
//  Read (READY, R0_en=1): latency 1. Cycle after accept, R0_data = entry contents, R0_valid=1.
//  R0_en=0: R0_valid=0 next cycle, R0_data holds last value (no garbage, no tracking of later writes).
//  Collision (R0_en & W0_en & same addr, same cycle): per lane, written lanes return new W0_data, unwritten lanes return old contents (write-first).
//  Back-to-back reads every cycle fully pipelined; no stalls, no backpressure.
//  Out-of-range address (addr >= DEPTH, non-pow2 DEPTH): write dropped; read returns 0 with R0_valid=1.
// CONFIGURATION
//  SRAM_OUTREG_EN defined: extra output register stage; read latency 2; R0_valid delayed with data.
//   Collision forwarding is resolved in stage 1. Reset clears both stages.
//  SRAM_OUTREG_EN undefined: single stage, latency 1 as above.
// STRUCTURE
//  Package masked_sram_pkg: state enum {INIT, READY}, function lane_merge(old,new,mask), localparam rule ADDR_W=$clog2(DEPTH).
//  Sub-module masked_sram_init_fsm: owns state, sweep counter, init_busy, init write enable/addr; muxed onto the write port.
//  Top: storage array, write-port mux, collision/forward logic, output stage(s).
// TESTING
//  Reset then idle: init_busy=1 for exactly DEPTH cycles, then 0. Read all entries -> all 0, R0_valid=1 each cycle after.
//  Write addr 5 data 0xABCDE mask 2'b11, read 5 next cycle -> R0_data=0xABCDE, R0_valid=1 one cycle later (two with SRAM_OUTREG_EN).
//  ram[7]=0xFFFFF. Write addr 7 data 0x00000 mask 2'b01 and read 7 same cycle -> 0xFFC00.
//  Read addr 3 once, then R0_en=0 and write addr 3 -> R0_data unchanged, R0_valid=0.
//  Reset asserted 10 cycles into the sweep after traffic: sweep restarts, init_busy high DEPTH more cycles, reads during it ignored.
//  Random 10k-op masked write/read vs scoreboard, DEPTH=200 non-pow2, MASK_W=4, LANE_W=8; out-of-range reads return 0.

Source files
------------

// File: rtl/masked_sram_pkg.sv
// Shared types and helpers for the masked 1W1R SRAM.
package masked_sram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_e;

  // Address width for a given depth. Depth 2 still needs a 1-bit address.
  function automatic int calc_addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  // Bit-level merge: the masked (written) value wins over the stored one.
  function automatic logic lane_merge(input logic old_v, input logic new_v, input logic mask_v);
    return mask_v ? new_v : old_v;
  endfunction

endpackage

// File: rtl/masked_sram_init_fsm.sv
// Post-reset clear sweep: walks every entry once, then parks in READY.
module masked_sram_init_fsm
  import masked_sram_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              busy_o,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // State and sweep counter registers; reset restarts the sweep at entry 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // One zero-write per cycle while sweeping; leave after the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_o    = 1'b0;
    addr_o  = cnt_q;
    busy_o  = (state_q == INIT);
    case (state_q)
      INIT: begin
        we_o = 1'b1;
        if (cnt_q == LAST) state_d = READY;
        else               cnt_d   = cnt_q + 1'b1;
      end
      READY:   ;
      default: state_d = INIT;
    endcase
  end

endmodule

// File: rtl/masked_sram_1w1r.sv
// Parametrised 1W1R synchronous RAM with per-lane write mask, self-clearing
// init sweep, write-first collision forwarding and held read data.
// Optional macro SRAM_OUTREG_EN adds a second output register (latency 2).
module masked_sram_1w1r
  import masked_sram_pkg::*;
#(
  parameter  int DEPTH  = 256,
  parameter  int LANE_W = 10,
  parameter  int MASK_W = 2,
  localparam int DATA_W = MASK_W * LANE_W,
  localparam int ADDR_W = calc_addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              W0_en,
  input  logic [ADDR_W-1:0] W0_addr,
  input  logic [DATA_W-1:0] W0_data,
  input  logic [MASK_W-1:0] W0_mask,
  input  logic              R0_en,
  input  logic [ADDR_W-1:0] R0_addr,
  output logic [DATA_W-1:0] R0_data,
  output logic              R0_valid,
  output logic              init_busy
);

`ifdef SRAM_OUTREG_EN
  localparam int STAGES = 2;
`else
  localparam int STAGES = 1;
`endif

  // Zero-extended depth so the range check also works for pow2 depths.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_we;
  logic [ADDR_W-1:0] init_addr;

  masked_sram_init_fsm #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_init (
    .clk_i  (clock),
    .rst_i  (reset),
    .busy_o (init_busy),
    .we_o   (init_we),
    .addr_o (init_addr)
  );

  logic w_in_rng, r_in_rng, rd_acc;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [MASK_W-1:0] wr_mask, fwd_mask;
  logic [DATA_W-1:0] rd_d;

  assign w_in_rng = ({1'b0, W0_addr} < DEPTH_X);
  assign r_in_rng = ({1'b0, R0_addr} < DEPTH_X);
  assign rd_acc   = R0_en & ~init_busy;

  // Write-port mux: the sweep owns the port until READY; out-of-range drops.
  always_comb begin
    wr_en   = W0_en & w_in_rng;
    wr_addr = W0_addr;
    wr_data = W0_data;
    wr_mask = W0_mask;
    if (init_busy) begin
      wr_en   = init_we;
      wr_addr = init_addr;
      wr_data = '0;
      wr_mask = '1;
    end
  end

  // Storage update, lane by lane.
  always_ff @(posedge clock) begin
    for (int g = 0; g < MASK_W; g++) begin
      if (wr_en && wr_mask[g]) mem[wr_addr][g*LANE_W +: LANE_W] <= wr_data[g*LANE_W +: LANE_W];
    end
  end

  // Read mux with write-first forwarding of the lanes being written this cycle.
  always_comb begin
    fwd_mask = (W0_en && (W0_addr == R0_addr)) ? W0_mask : '0;
    rd_d     = '0;
    if (r_in_rng) begin
      for (int b = 0; b < DATA_W; b++) rd_d[b] = lane_merge(mem[R0_addr][b], W0_data[b], fwd_mask[b / LANE_W]);
    end
  end

  // Valid travels with the data; bit 0 is the accept strobe itself.
  logic [STAGES:0]   vld_pipe;
  logic [STAGES-1:0] vld_q;
  logic [DATA_W-1:0] data1_q;

  assign vld_pipe = {vld_q, rd_acc};

  // Stage 1: capture accepted reads, otherwise hold the last value.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q   <= '0;
      data1_q <= '0;
    end else begin
      vld_q <= vld_pipe[STAGES-1:0];
      if (rd_acc) data1_q <= rd_d;
    end
  end

`ifdef SRAM_OUTREG_EN
  logic [DATA_W-1:0] data2_q;

  // Stage 2: retime stage-1 data only when it carried a fresh read.
  always_ff @(posedge clock) begin
    if (reset)         data2_q <= '0;
    else if (vld_q[0]) data2_q <= data1_q;
  end

  assign R0_data = data2_q;
`else
  assign R0_data = data1_q;
`endif

  assign R0_valid = vld_pipe[STAGES];

endmodule
